// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/opcode sequencer.
// Opcode values follow the downstream 8-bit combinational ALU.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WB      = 2'd3
    } seq_state_t;

    localparam logic [3:0] SEL_ZERO  = 4'h0;
    localparam logic [3:0] SEL_PASSB = 4'h1;
    localparam logic [3:0] SEL_PASSA = 4'h2;
    localparam logic [3:0] SEL_ONES  = 4'h3;
    localparam logic [3:0] SEL_NOTA  = 4'h4;
    localparam logic [3:0] SEL_NOTB  = 4'h5;
    localparam logic [3:0] SEL_AND   = 4'h6;
    localparam logic [3:0] SEL_OR    = 4'h7;
    localparam logic [3:0] SEL_ADD   = 4'h8;
    localparam logic [3:0] SEL_SUB   = 4'h9;
    localparam logic [3:0] SEL_INC   = 4'hA;
    localparam logic [3:0] SEL_DEC   = 4'hB;
    localparam logic [3:0] SEL_NEG   = 4'hC;
    localparam logic [3:0] SEL_CMP   = 4'hD;
    localparam logic [3:0] SEL_XOR   = 4'hE;
    localparam logic [3:0] SEL_XNOR  = 4'hF;

    // Opcodes below this leave the ALU flags undefined.
    localparam logic [3:0] FLAG_OP_MIN = 4'h8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_S = 3;

    function automatic logic [3:0] pack_flags(input logic s, input logic p,
                                              input logic c, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_S] = s;
        f[FLAG_P] = p;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

    function automatic logic is_flag_op(input logic [3:0] sel);
        return (sel >= FLAG_OP_MIN);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file for the sequencer: two operand read ports, a debug
// peek port and one synchronous write port.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] peek_addr,
    output logic [DW-1:0] peek_data
);

    logic [DW-1:0] regs_r [NREGS];

    // Storage array with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a   = regs_r[raddr_a];
    assign rdata_b   = regs_r[raddr_b];
    assign peek_data = regs_r[peek_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Serial instruction sequencer in front of the combinational ALU: issues
// registered operands, captures the ALU result, then writes it back.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_sel,
    input  logic [1:0]    in_rd,
    input  logic [1:0]    in_ra,
    input  logic [1:0]    in_rb,
    input  logic          in_use_imm,
    input  logic [DW-1:0] in_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_sel,
    input  logic [DW-1:0] alu_su,
    input  logic          alu_z,
    input  logic          alu_c,
    input  logic          alu_s,
    input  logic          alu_p,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [1:0]    res_rd,
    output logic [3:0]    flags,
    input  logic [1:0]    peek_addr,
    output logic [DW-1:0] peek_data
);

    seq_state_t    state_r;
    seq_state_t    state_nx_s;
    logic          ready_s;
    logic          load_s;
    logic          capture_s;
    logic          enter_wb_s;
    logic          wb_s;
    logic [1:0]    rd_r;
    logic [DW-1:0] res_r;
    logic [3:0]    cflags_r;
    logic [DW-1:0] rf_a_s;
    logic [DW-1:0] rf_b_s;

    alu_seq_regfile #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wb_s),
        .waddr     (rd_r),
        .wdata     (res_r),
        .raddr_a   (in_ra),
        .rdata_a   (rf_a_s),
        .raddr_b   (in_rb),
        .rdata_b   (rf_b_s),
        .peek_addr (peek_addr),
        .peek_data (peek_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_nx_s = state_r;
        ready_s    = 1'b0;
        load_s     = 1'b0;
        capture_s  = 1'b0;
        enter_wb_s = 1'b0;
        wb_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (in_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                capture_s  = 1'b1;
                state_nx_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Hold cycle kept so latency matches a registered-ALU build.
                enter_wb_s = 1'b1;
                state_nx_s = ST_WB;
            end
            ST_WB: begin
                wb_s       = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign in_ready = ready_s;

    // Operand issue, result capture, writeback outputs and committed flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a     <= {DW{1'b0}};
            alu_b     <= {DW{1'b0}};
            alu_sel   <= 4'h0;
            rd_r      <= 2'd0;
            res_r     <= {DW{1'b0}};
            cflags_r  <= 4'h0;
            res_valid <= 1'b0;
            res_data  <= {DW{1'b0}};
            res_rd    <= 2'd0;
            flags     <= 4'h0;
        end else begin
            if (load_s) begin
                alu_a   <= rf_a_s;
                alu_b   <= in_use_imm ? in_imm : rf_b_s;
                alu_sel <= in_sel;
                rd_r    <= in_rd;
            end
            if (capture_s) begin
                res_r    <= alu_su;
                cflags_r <= pack_flags(alu_s, alu_p, alu_c, alu_z);
            end
            res_valid <= enter_wb_s;
            if (enter_wb_s) begin
                res_data <= res_r;
                res_rd   <= rd_r;
            end
            // alu_sel is still the issued opcode here; it only reloads in IDLE.
            if (wb_s && is_flag_op(alu_sel)) begin
                flags <= cflags_r;
            end
        end
    end

endmodule
